// File: rtl/sha256_msg_loader.sv
// SHA-256 message loader. Packs a byte stream into 512-bit blocks, adds the
// FIPS 180-4 padding and length, and streams each block to the core as 16 words.
module sha256_msg_loader #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 61
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [$clog2(DATA_W/8):0] in_nbytes,
    input  logic                      busy,
    output logic [31:0]               data,
    output logic                      write_enable,
    output logic                      first_block,
    output logic                      last_block,
    output logic                      msg_done
);
    localparam int NB  = DATA_W / 8;
    localparam int NBW = $clog2(NB) + 1;

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_PAD, S_XTRA, S_WAIT, S_SEND} state_t;

    state_t           state_q;
    logic [31:0]      buf_q [16];
    logic [LEN_W-1:0] nbytes_q;
    logic [4:0]       cnt_q;
    logic             first_q;
    logic             pad80_q;
    logic             final_q;
    logic             ended_q;
    logic             full_q;
    logic             in_ready_q;
    logic             we_q;
    logic             first_blk_q;
    logic             last_blk_q;
    logic             done_q;
    logic [31:0]      data_q;

    logic [3:0]        wi;
    logic [1:0]        bi;
    logic              accept;
    logic              blk_fill;
    logic [NBW-1:0]    inc;
    logic [LEN_W-1:0]  nbytes_nxt;
    logic [DATA_W-1:0] beat_masked;
    logic [31:0]       beat_word;
    logic [31:0]       pad_word;
    logic [63:0]       len_bits;

    // The write position is the byte count modulo one block.
    assign wi         = nbytes_q[5:2];
    assign bi         = nbytes_q[1:0];
    assign accept     = in_valid && in_ready_q;
    assign inc        = in_last ? in_nbytes : NBW'(NB);
    assign nbytes_nxt = nbytes_q + LEN_W'(inc);
    assign blk_fill   = (nbytes_nxt[5:0] == 6'd0) && (inc != '0);
    assign pad_word   = 32'h8000_0000 >> {bi, 3'b000};
    assign len_bits   = 64'(nbytes_q) << 3;

    // NOTE: every variable gets a value before any conditional update so no latch is inferred.
    always_comb begin
        beat_masked = in_data;
        for (int j = 0; j < NB; j++) begin
            if (in_last && (j >= int'(in_nbytes))) begin
                beat_masked[DATA_W-1-8*j -: 8] = 8'h00;
            end
        end
        beat_word = (32'(beat_masked) << (32 - DATA_W)) >> {bi, 3'b000};
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            nbytes_q    <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            pad80_q     <= 1'b0;
            final_q     <= 1'b0;
            ended_q     <= 1'b0;
            full_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            we_q        <= 1'b0;
            first_blk_q <= 1'b0;
            last_blk_q  <= 1'b0;
            done_q      <= 1'b0;
            data_q      <= '0;
            // NOTE: the buffer is reset because zero fill relies on it holding zeros.
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            in_ready_q  <= 1'b0;
            first_blk_q <= 1'b0;
            last_blk_q  <= 1'b0;
            done_q      <= 1'b0;
            unique case (state_q)
                S_IDLE, S_FILL: begin
                    in_ready_q <= !(accept && (in_last || blk_fill));
                    if (accept) begin
                        buf_q[wi] <= buf_q[wi] | beat_word;
                        nbytes_q  <= nbytes_nxt;
                        if (state_q == S_IDLE) begin
                            first_q <= 1'b1;
                        end
                        if (in_last) begin
                            ended_q <= 1'b1;
                            full_q  <= blk_fill;
                            state_q <= S_PAD;
                        end else if (blk_fill) begin
                            state_q <= S_WAIT;
                        end else begin
                            state_q <= S_FILL;
                        end
                    end
                end
                S_PAD: begin
                    if (!full_q) begin
                        buf_q[wi] <= buf_q[wi] | pad_word;
                        pad80_q   <= 1'b1;
                    end
                    // Length fits behind the marker only if the marker sits in words 0..13.
                    if (!full_q && (wi <= 4'd13)) begin
                        buf_q[14] <= len_bits[63:32];
                        buf_q[15] <= len_bits[31:0];
                        final_q   <= 1'b1;
                    end
                    state_q <= S_WAIT;
                end
                S_XTRA: begin
                    if (!pad80_q) begin
                        buf_q[0] <= 32'h8000_0000;
                    end
                    buf_q[14] <= len_bits[63:32];
                    buf_q[15] <= len_bits[31:0];
                    final_q   <= 1'b1;
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    if (!busy) begin
                        data_q      <= buf_q[0];
                        buf_q[0]    <= '0;
                        we_q        <= 1'b1;
                        first_blk_q <= first_q;
                        last_blk_q  <= final_q;
                        cnt_q       <= 5'd1;
                        state_q     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (!cnt_q[4]) begin
                        data_q              <= buf_q[cnt_q[3:0]];
                        buf_q[cnt_q[3:0]]   <= '0;
                        cnt_q               <= cnt_q + 5'd1;
                    end else begin
                        we_q    <= 1'b0;
                        data_q  <= '0;
                        cnt_q   <= '0;
                        first_q <= 1'b0;
                        full_q  <= 1'b0;
                        if (final_q) begin
                            done_q     <= 1'b1;
                            nbytes_q   <= '0;
                            pad80_q    <= 1'b0;
                            final_q    <= 1'b0;
                            ended_q    <= 1'b0;
                            in_ready_q <= 1'b1;
                            state_q    <= S_IDLE;
                        end else if (ended_q) begin
                            state_q <= S_XTRA;
                        end else begin
                            in_ready_q <= 1'b1;
                            state_q    <= S_FILL;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign data         = data_q;
    assign write_enable = we_q;
    assign first_block  = first_blk_q;
    assign last_block   = last_blk_q;
    assign msg_done     = done_q;

endmodule

// File: doc/sha256_msg_loader.md
# sha256_msg_loader

Parametrised front-end for the SHA-256 core. It accepts a raw message as a stream of 8-, 16- or 32-bit beats under a valid/ready handshake and performs FIPS 180-4 padding: the 0x80 marker, zero fill, and a 64-bit big-endian bit length. It presents each 512-bit block to the core as 16 consecutive 32-bit words with `write_enable`, `first_block` and `last_block`, and holds each block until the core's `busy` is low. This moves padding and block framing, previously driven by hand from the bench, into RTL.

## Interface
- `DATA_W`, 32: input beat width; legal values 8, 16, 32.
- `LEN_W`, 61: message byte-counter width; maximum message is 2^LEN_W − 1 bytes.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `in_data` in DATA_W: message bytes, first byte in the MSBs.
- `in_valid` in 1: beat valid.
- `in_ready` out 1: beat accepted when `in_valid && in_ready`.
- `in_last` in 1: this beat is the final beat of the message.
- `in_nbytes` in clog2(DATA_W/8)+1: valid bytes on the last beat, MSB-aligned, range 0..DATA_W/8. Ignored unless `in_last` is set. A value of 0 on a lone last beat encodes the empty message.
- `busy` in 1: core is compressing; no block is started while high.
- `data` out 32: message word to the core.
- `write_enable` out 1: high for exactly 16 consecutive cycles per block.
- `first_block` out 1: high only during word 0 of the message's first block.
- `last_block` out 1: high only during word 0 of the message's final block.
- `msg_done` out 1: one-cycle pulse the cycle after word 15 of the final block.

## Operation
- 16×32 block buffer, word index `wi` (0..15), byte lane `bi` (0..3), byte counter `nbytes` (LEN_W bits), and flags `first`, `pad80_done`, `final`.
- States are IDLE, FILL, PAD, XTRA, WAIT and SEND.
- IDLE: `in_ready`=1. The first accepted beat goes to FILL handling and sets `first`.
- FILL: `in_ready`=1. Each accepted beat writes DATA_W/8 bytes at (`wi`,`bi`). Beats never straddle words because DATA_W divides 32.
  - `nbytes` increments by DATA_W/8, or by `in_nbytes` on the last beat.
  - If the block fills on a non-last beat, go to WAIT.
  - On the last beat, go to PAD.
- PAD, one cycle: write 0x80 at the next free byte if the block is not full, and set `pad80_done`.
  - If the 0x80 lands in word ≤13, write length = `nbytes`×8 (64-bit, big-endian) into words 14–15, set `final`, and go to WAIT.
  - Otherwise, go to WAIT with `final`=0, then continue to XTRA after that block is sent.
- XTRA, one cycle: the buffer is already zero. Write 0x80000000 to word 0 if `pad80_done`=0. Write the length to words 14–15, set `final`, and go to WAIT.
- WAIT: `in_ready`=0. Go to SEND on the first cycle `busy`=0.
- SEND: 16 cycles, words 0..15 on `data`. Each word is cleared in the buffer as it is read.
  - After word 15: if `final`, pulse `msg_done` and go to IDLE.
  - Else if the message ended, go to XTRA.
  - Else go to FILL with `wi`=`bi`=0.
  - `first` clears after the first block is sent.
- `busy` is sampled only in WAIT. A `busy` rise during SEND does not interrupt the 16-word burst.
- Reset at any time:
  - state goes to IDLE, the buffer and counters are cleared, and all outputs go to 0;
  - a partially sent block is abandoned, with no `msg_done`;
  - `in_ready` goes high the first cycle after `reset` is released.

## Timing
- Reset values are 0 for `in_ready`, `data`, `write_enable`, `first_block`, `last_block` and `msg_done`.
- `data`, `write_enable`, `first_block` and `last_block` are registered. Word 0 appears the cycle after WAIT sees `busy`=0, then one word per cycle with no gaps.
- Latency with `busy`=0: last beat accepted at cycle T; PAD at T+1; WAIT at T+2; word 0 at T+3; word 15 at T+18; `msg_done` at T+19.
- A full non-final block goes from its final beat at T to WAIT at T+1 and word 0 at T+2.
- Extra block: XTRA occupies the cycle after the previous word 15, then WAIT, then words.
- A single-block message asserts `first_block` and `last_block` together on word 0.
- `in_valid` without `in_ready` has no effect. `in_data` is sampled only on a handshake.

## Test plan
- DATA_W=8, "abc" (0x61,0x62,0x63 with last on 0x63, `in_nbytes`=1):
  - one block: word0=0x61626380, words1–14=0, word15=0x00000018;
  - `first_block`=`last_block`=1 on word 0;
  - `msg_done` 16 cycles after word 0.
- DATA_W=32, 56 bytes of 0x00, last `in_nbytes`=4:
  - block 1: word14=0x80000000, word15=0;
  - block 2 (via XTRA): words 0–13=0, word14=0, word15=0x000001C0, `last_block` on its word 0.
- DATA_W=16, 64-byte message:
  - block 1 holds the data only;
  - block 2 has word0=0x80000000 and word15=0x00000200;
  - `first_block` only on block 1 word 0.
- Empty message (DATA_W=32, single beat `in_last`=1, `in_nbytes`=0):
  - word0=0x80000000, all other words 0.
- `busy` held high for 40 cycles after block 1:
  - `write_enable` stays 0 and `in_ready` stays 0;
  - block 2 word 0 appears the cycle after `busy` falls;
  - a `busy` rise mid-SEND does not stall the burst.
- `reset` asserted at SEND word 7:
  - the next cycle all outputs are 0 and there is no `msg_done`;
  - a following "abc" message produces correct output with `first_block`=1.
